// File: rtl/adder_tree_seq.sv
// adder_tree_seq: pipelined binary adder tree that sums the valid lanes of a packed input bus.
//   Parameters : DATA_WIDTH (lane width), NUM_IN (lane count, power of two >= 2)
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset, clears every stage
//   i_en       : pipeline advance; low holds every stage
//   i_valid    : per-lane valid, bit k qualifies lane k
//   i_data_bus : lane k at [k*DATA_WIDTH +: DATA_WIDTH]
//   o_valid    : at least one lane of the emerging vector was valid
//   o_data_bus : sum of the valid lanes (DATA_WIDTH+LEVELS bits)
//   o_valid_cnt: number of lanes that contributed to o_data_bus
//   Macro ADDER_TREE_SIGNED_EN: lanes are two's-complement and sign-extended; otherwise unsigned.
module adder_tree_seq #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_IN = 4,
  localparam int LEVELS = $clog2(NUM_IN),
  localparam int OUT_WIDTH = DATA_WIDTH + LEVELS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_en,
  input  logic [NUM_IN-1:0]            i_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] i_data_bus,
  output logic                         o_valid,
  output logic [OUT_WIDTH-1:0]         o_data_bus,
  output logic [LEVELS:0]              o_valid_cnt
);
`ifdef ADDER_TREE_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif
  // Level 0 is the masked input; levels 1..LEVELS are the registered stages.
  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    localparam int N = NUM_IN >> l;
    localparam int W = DATA_WIDTH + l;
    logic [W-1:0] d [N];
    logic [l:0]   c [N];
    logic [N-1:0] v;
    if (l == 0) begin : g_in
      assign v = i_valid;
      always_comb
        for (int k = 0; k < N; k++) begin
          d[k] = i_valid[k] ? i_data_bus[k*DATA_WIDTH +: DATA_WIDTH] : '0;
          c[k] = i_valid[k];
        end
    end else begin : g_st
      logic [W-1:0] d_nx [N];
      logic [l:0]   c_nx [N];
      logic [N-1:0] v_nx;
      // Invalid children already carry data 0 and count 0, so they add nothing.
      always_comb
        for (int k = 0; k < N; k++) begin
          v_nx[k] = g_lvl[l-1].v[2*k] | g_lvl[l-1].v[2*k+1];
          d_nx[k] = v_nx[k] ? {SGN & g_lvl[l-1].d[2*k][W-2], g_lvl[l-1].d[2*k]}
                            + {SGN & g_lvl[l-1].d[2*k+1][W-2], g_lvl[l-1].d[2*k+1]} : '0;
          c_nx[k] = {1'b0, g_lvl[l-1].c[2*k]} + {1'b0, g_lvl[l-1].c[2*k+1]};
        end
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          v <= '0;
          d <= '{default: '0};
          c <= '{default: '0};
        end else if (i_en) begin
          v <= v_nx;
          d <= d_nx;
          c <= c_nx;
        end
    end
  end
  assign o_valid     = g_lvl[LEVELS].v[0];
  assign o_data_bus  = g_lvl[LEVELS].d[0];
  assign o_valid_cnt = g_lvl[LEVELS].c[0];
endmodule

// File: doc/adder_tree_seq.md
ADDER_TREE_SEQ -- requirements
Module: adder_tree_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: width of each input lane.
REQ-002 SHALL have parameter NUM_IN, default 4: number of input lanes; power of two, >= 2.
REQ-003 SHALL derive localparam LEVELS = log2(NUM_IN) (pipeline depth) and OUT_WIDTH = DATA_WIDTH + LEVELS.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_en  input  1  pipeline advance enable; low = stall.
REQ-007 SHALL have port i_valid  input  NUM_IN  per-lane valid; bit k qualifies lane k.
REQ-008 SHALL have port i_data_bus  input  NUM_IN*DATA_WIDTH  lane k at [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port o_valid  output  1  output sum valid.
REQ-010 SHALL have port o_data_bus  output  OUT_WIDTH  sum of all valid lanes.
REQ-011 SHALL have port o_valid_cnt  output  LEVELS+1  number of valid lanes contributing to o_data_bus.

Function
REQ-012 SHALL implement a binary reduction tree of LEVELS registered stages; stage s holds NUM_IN>>s nodes of width DATA_WIDTH+s, each with a node-valid bit and a valid-lane count.
REQ-013 SHALL treat an invalid lane (i_valid[k]=0) as contributing 0 to the sum and 0 to the count, regardless of its data value.
REQ-014 SHALL set each node-valid to the OR of its two children's valid bits; a node with both children invalid SHALL register data 0 and count 0.
REQ-015 SHALL zero-extend each child by one bit before adding, so no stage overflows; the full sum of NUM_IN lanes of all-ones SHALL be representable in OUT_WIDTH.
REQ-016 SHALL present the result of the input vector sampled at enabled edge E on o_data_bus/o_valid/o_valid_cnt after exactly LEVELS enabled edges, counting E (NUM_IN=2 gives 1-cycle latency).
REQ-017 SHALL, when i_en=0 at a rising edge, hold every stage register including outputs; no input is sampled and no in-flight result is lost or duplicated.
REQ-018 SHALL accept a new input vector on every enabled edge (throughput 1 vector/cycle); consecutive vectors SHALL not interfere.
REQ-019 SHALL drive o_valid=1 iff at least one lane of the corresponding sampled vector was valid; when o_valid=0, o_data_bus=0 and o_valid_cnt=0.
REQ-020 SHALL drive all outputs directly from registers; no combinational path from any input to any output.

Reset
REQ-021 SHALL, while rst=1, immediately clear all stage registers, o_valid=0, o_data_bus=0, o_valid_cnt=0, independent of clk and i_en.
REQ-022 SHALL discard all in-flight vectors on reset, including reset mid-stream; first sample after deassertion is the first enabled edge with rst=0.

Configuration
REQ-023 SHALL use macro ADDER_TREE_SIGNED_EN to select the arithmetic mode.
REQ-024 SHALL, with ADDER_TREE_SIGNED_EN defined, treat lanes as two's-complement and sign-extend each child by one bit per stage; o_data_bus is signed OUT_WIDTH.
REQ-025 SHALL, without ADDER_TREE_SIGNED_EN, treat lanes as unsigned with zero-extension (REQ-015); invalid-lane and count behaviour identical in both modes.

Verification (NUM_IN=4, DATA_WIDTH=4, LEVELS=2, OUT_WIDTH=6)
REQ-026 SHALL cover: i_valid=4'b1111, lanes {4,3,2,1}, i_en=1 -> two enabled edges later o_valid=1, o_data_bus=6'd10, o_valid_cnt=3'd4.
REQ-027 SHALL cover: i_valid=4'b1111, all lanes 4'hF, unsigned -> o_data_bus=6'd60, o_valid_cnt=4; signed build -> o_data_bus=6'h3C (-4).
REQ-028 SHALL cover: i_valid=4'b0101, all lanes 4'hF -> o_data_bus=6'd30, o_valid_cnt=2; then i_valid=4'b0000 -> o_valid=0, o_data_bus=0, o_valid_cnt=0.
REQ-029 SHALL cover: back-to-back vectors sums 10, 20, 30 with i_en=0 for 3 cycles after the second -> outputs hold through stall, emit 10, 20, 30 in order, none dropped or repeated.
REQ-030 SHALL cover: rst pulsed high between clock edges with two vectors in flight -> outputs 0 immediately; neither in-flight sum ever appears after deassertion.
